// File: rtl/uart_fifo_if.sv
// Byte-stream side of the buffered UART: TX write port, RX read port, levels and error pulses.
// The UART core takes the slave modport; the producer/consumer takes the master modport.
interface uart_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] txd;
  logic                  txv;
  logic                  tx_rdy;
  logic                  tx_active;
  logic [LW-1:0]         tx_level;
  logic [DATA_WIDTH-1:0] rxd;
  logic                  rxv;
  logic                  rxr;
  logic [LW-1:0]         rx_level;
  logic                  frame_err;
  logic                  parity_err;
  logic                  overrun;

  modport master (
    output txd, txv, rxr,
    input  tx_rdy, tx_active, tx_level, rxd, rxv, rx_level, frame_err, parity_err, overrun
  );

  modport slave (
    input  txd, txv, rxr,
    output tx_rdy, tx_active, tx_level, rxd, rxv, rx_level, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_fifo.sv
// Single-clock UART with programmable baud tick and independent TX/RX FIFOs.
// Reports framing, parity and overrun errors as one-cycle pulses.
module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full is judged on the current level, so a push onto a full FIFO is refused even with a same-cycle pop
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int EVEN       = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 rx,
  output logic                 tx,
  uart_fifo_if.slave           bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DW_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD = (EVEN == 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DIV_WIDTH-1:0] tick_cnt, div_q;
  logic                 tick;
  logic                 rx_meta, rx_s;

  state_t               tx_state, tx_state_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n, tx_head;
  logic [CW-1:0]        tx_os, tx_os_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic                 tx_par, tx_par_n, tx_pop, tx_load, tx_end, tx_full, tx_empty;

  state_t               rx_state, rx_state_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n, rx_head;
  logic [CW-1:0]        rx_os, rx_os_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic                 rx_par, rx_par_n, rx_ferr, rx_ferr_n, rx_sample, rx_done;
  logic                 rx_full, rx_empty, rx_push, stop_low, par_bad;
  logic                 fe_n, pe_n, ov_n;

  // The divisor is latched at each wrap so a change never produces a truncated tick period
  assign tick = (tick_cnt == div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      div_q    <= div;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= div;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(bus.txv), .wdata(bus.txd), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .level(bus.tx_level)
  );

  uart_fifo_buf #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift), .pop(bus.rxr),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .level(bus.rx_level)
  );

  assign bus.tx_rdy    = !tx_full && !rst;
  assign bus.rxv       = !rx_empty;
  assign bus.rxd       = rx_empty ? '0 : rx_head;
  assign bus.tx_active = (tx_state != S_IDLE);
  assign tx_end        = tick && (tx_os == OS_LAST);

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_par_n   = tx_par;
    tx_load    = 1'b0;
    if (tick && tx_state != S_IDLE) tx_os_n = tx_end ? '0 : tx_os + 1'b1;
    case (tx_state)
      S_IDLE:   tx_load = !tx_empty;
      S_START:  if (tx_end) tx_state_n = S_DATA;
      S_DATA: begin
        if (tx_end) begin
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + 1'b1;
          if (tx_bit == DW_LAST) begin
            tx_bit_n   = '0;
            tx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: if (tx_end) tx_state_n = S_STOP;
      S_STOP: begin
        if (tx_end) begin
          tx_bit_n = tx_bit + 1'b1;
          if (tx_bit == SB_LAST) begin
            tx_state_n = S_IDLE;
            tx_load    = !tx_empty;
          end
        end
      end
      default:  tx_state_n = S_IDLE;
    endcase
    // Loading from STOP as well as IDLE gives back-to-back frames with no idle gap
    if (tx_load) begin
      tx_state_n = S_START;
      tx_shift_n = tx_head;
      tx_par_n   = (^tx_head) ^ PAR_ODD;
      tx_os_n    = '0;
      tx_bit_n   = '0;
    end
    tx_pop = tx_load;
  end

  always_comb begin
    case (tx_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = tx_shift[0];
      S_PARITY: tx = tx_par;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_shift <= '0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_par   <= tx_par_n;
    end
  end

  // The start bit is re-checked half a bit after detection; later bits are sampled a full bit apart
  assign rx_sample = tick && (rx_os == ((rx_state == S_START) ? OS_MID : OS_LAST));

  always_comb begin
    rx_state_n = rx_state;
    rx_shift_n = rx_shift;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_par_n   = rx_par;
    rx_ferr_n  = rx_ferr;
    rx_done    = 1'b0;
    if (tick && rx_state != S_IDLE) rx_os_n = rx_sample ? '0 : rx_os + 1'b1;
    case (rx_state)
      S_IDLE: begin
        if (tick && !rx_s) begin
          rx_state_n = S_START;
          rx_os_n    = '0;
          rx_bit_n   = '0;
          rx_ferr_n  = 1'b0;
        end
      end
      S_START:  if (rx_sample) rx_state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (rx_sample) begin
          rx_shift_n = {rx_s, rx_shift[DATA_WIDTH-1:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == DW_LAST) begin
            rx_bit_n   = '0;
            rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_n   = rx_s;
          rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_sample) begin
          rx_ferr_n = rx_ferr | !rx_s;
          rx_bit_n  = rx_bit + 1'b1;
          if (rx_bit == SB_LAST) begin
            rx_done    = 1'b1;
            rx_state_n = S_IDLE;
          end
        end
      end
      default:  rx_state_n = S_IDLE;
    endcase
  end

  assign stop_low = rx_ferr | !rx_s;
  assign par_bad  = (PARITY != 0) && (((^rx_shift) ^ rx_par) != PAR_ODD);
  assign fe_n     = rx_done && stop_low;
  assign pe_n     = rx_done && !stop_low && par_bad;
  assign ov_n     = rx_done && !stop_low && !par_bad && rx_full;
  assign rx_push  = rx_done && !stop_low && !par_bad && !rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state       <= S_IDLE;
      rx_shift       <= '0;
      rx_os          <= '0;
      rx_bit         <= '0;
      rx_par         <= 1'b0;
      rx_ferr        <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      rx_state       <= rx_state_n;
      rx_shift       <= rx_shift_n;
      rx_os          <= rx_os_n;
      rx_bit         <= rx_bit_n;
      rx_par         <= rx_par_n;
      rx_ferr        <= rx_ferr_n;
      bus.frame_err  <= fe_n;
      bus.parity_err <= pe_n;
      bus.overrun    <= ov_n;
    end
  end
endmodule
